// File: rtl/fir_parallel_l_if.sv
// rtl/fir_parallel_l_if.sv - sample, coefficient-write and result signals of the L-parallel FIR
interface fir_parallel_l_if #(
    parameter int L    = 2,
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int LW   = 36
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic              in_valid;
    logic [L*DW-1:0]   data_in;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [CW-1:0]     coef_data;
    logic              out_valid;
    logic [L*LW-1:0]   data_out;

    modport master (
        output in_valid, data_in, coef_we, coef_addr, coef_data,
        input  out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, coef_we, coef_addr, coef_data,
        output out_valid, data_out
    );
endinterface

// File: rtl/fir_parallel_l.sv
// rtl/fir_parallel_l.sv - L-parallel direct FIR, L samples in and out per clk; option macro FIR_OUT_SAT_EN
module fir_parallel_l #(
    parameter int L     = 2,
    parameter int TAPS  = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACCW  = DW + CW + $clog2(TAPS)
`ifdef FIR_OUT_SAT_EN
    ,
    parameter int SHIFT = 15,
    parameter int OUT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    fir_parallel_l_if.slave  bus
);
    localparam int PW = DW + CW;
    localparam int WL = TAPS + L - 1;
    localparam int HL = (TAPS > 1) ? TAPS - 1 : 1;
`ifdef FIR_OUT_SAT_EN
    localparam int LW = OUT_W;
`else
    localparam int LW = ACCW;
`endif

    // Coefficient bank h[k]
    logic signed [CW-1:0] coef [TAPS];

    // History of previous samples; hist[0] is the newest one before the current block
    logic signed [DW-1:0] hist [HL];

    // Sample window by age: win[0] is the newest (lane L-1), win[WL-1] the oldest needed
    logic signed [DW-1:0] win [WL];

    // S1 product registers, one per lane and tap
    logic signed [PW-1:0] prod [L][TAPS];
    logic                 v1;

    // Per-lane full-precision sums of the S1 products
    logic signed [ACCW-1:0] lane_sum [L];

    // Build the sample window from the incoming block and the stored history
    always_comb begin
        for (int j = 0; j < L; j++) begin
            win[j] = bus.data_in[(L-1-j)*DW +: DW];
        end
        for (int m = 0; m < TAPS - 1; m++) begin
            win[L+m] = hist[m];
        end
    end

    // Coefficient register writes; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Delay line: shift by L on a valid block, hold otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int m = 0; m < HL; m++) begin
                hist[m] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int m = 0; m < TAPS - 1; m++) begin
                hist[m] <= win[m];
            end
        end
    end

    // S1: register every lane/tap product; same-edge coefficient writes are not yet visible here
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1 <= 1'b0;
            for (int i = 0; i < L; i++) begin
                for (int k = 0; k < TAPS; k++) begin
                    prod[i][k] <= '0;
                end
            end
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < L; i++) begin
                    for (int k = 0; k < TAPS; k++) begin
                        prod[i][k] <= win[L-1-i+k] * coef[k];
                    end
                end
            end
        end
    end

    // Sign-extend each product to ACCW and sum per lane; ACCW has headroom for TAPS worst-case terms
    always_comb begin
        for (int i = 0; i < L; i++) begin
            lane_sum[i] = '0;
            for (int k = 0; k < TAPS; k++) begin
                lane_sum[i] = lane_sum[i] + ACCW'(prod[i][k]);
            end
        end
    end

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACCW:0] MAXV = $signed({{(ACCW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACCW:0] MINV = ~MAXV;

    logic signed [ACCW-1:0] acc [L];
    logic                   v2;
    logic signed [ACCW:0]   rnd [L];
    logic signed [ACCW:0]   sat [L];

    // S2: register the full-precision lane sums
    always_ff @(posedge clk) begin
        if (!reset) begin
            v2 <= 1'b0;
            for (int i = 0; i < L; i++) begin
                acc[i] <= '0;
            end
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int i = 0; i < L; i++) begin
                    acc[i] <= lane_sum[i];
                end
            end
        end
    end

    // Round half-up by adding half an LSB before the arithmetic shift, then clamp to OUT_W
    always_comb begin
        for (int i = 0; i < L; i++) begin
            rnd[i] = ($signed({acc[i][ACCW-1], acc[i]}) + HALF) >>> SHIFT;
            if (rnd[i] > MAXV) begin
                sat[i] = MAXV;
            end else if (rnd[i] < MINV) begin
                sat[i] = MINV;
            end else begin
                sat[i] = rnd[i];
            end
        end
    end

    // S3: register the saturated lanes; data_out holds between valid blocks
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                for (int i = 0; i < L; i++) begin
                    bus.data_out[i*LW +: LW] <= sat[i][LW-1:0];
                end
            end
        end
    end
`else
    // S2: register the full-precision lane sums to data_out; data_out holds between valid blocks
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.out_valid <= v1;
            if (v1) begin
                for (int i = 0; i < L; i++) begin
                    bus.data_out[i*LW +: LW] <= lane_sum[i];
                end
            end
        end
    end
`endif
endmodule
